button_event_arbiter: RTL and testbench
=======================================

// Module: button_event_arbiter
// PURPOSE
//  Turns N debounced button levels into a single stream of press and long-press events.
//  Per button: rising-edge detect, long-hold timer, pending flags.
//  A round-robin arbiter serialises pending events onto one valid/ready port.
//  Sits between the per-button debounce stages and the FSM/UI logic that consumes key events.
// PARAMETERS
//  N           4          number of buttons
//  IDW         2          width of evt_id; must equal clog2(N)
//  LONG_CYCLES 50000000   hold time in clk cycles, counted from the press edge, that fires a long event
//  CW          26         hold-counter width; must satisfy 2**CW > LONG_CYCLES
// PORTS
//  clk          in   1    system clock, all logic on posedge
//  rst_n        in   1    synchronous reset, active low
//  btn_level    in   N    debounced button levels, 1 = pressed, synchronous to clk
//  evt_valid    out  1    output event present
//  evt_ready    in   1    consumer accepts the event on this edge when evt_valid=1
//  evt_id       out  IDW  button index of the event
//  evt_long     out  1    0 = press event, 1 = long-press event
//  overrun      out  N    sticky: an event for button i was merged (lost)
//  overrun_clr  in   1    clears all overrun bits
// BEHAVIOUR
//  Reset (rst_n=0 at posedge):
//   - evt_valid=0, evt_id=0, evt_long=0, overrun=0.
//   - All pending, armed and counter state cleared.
//   - btn_prev set to all ones, so a button held through reset produces no event.
//   - rr_last set to N-1, so button 0 has first priority.
//   - Reset mid-handshake drops the held event and all pending events.
//  Edge detect: rise[i] = btn_level[i] & ~btn_prev[i]; btn_prev <= btn_level every cycle.
//  On rise[i]:
//   - short_pend[i] <= 1; armed[i] <= 1; cnt[i] <= 0.
//  Hold timer:
//   - While armed[i] & btn_level[i]: cnt[i] increments.
//   - Increment that makes cnt[i] == LONG_CYCLES: long_pend[i] <= 1 and armed[i] <= 0. One long event per press.
//   - btn_level[i]=0: armed[i] <= 0 and cnt[i] <= 0. Release itself generates no event.
//  Output register load:
//   - Loads when evt_valid=0, or on a transfer edge (evt_valid & evt_ready), which gives back-to-back events.
//   - Loads only if some req[i] = short_pend[i] | long_pend[i] is set.
//   - Winner: first i with req[i] set, scanning rr_last+1, rr_last+2, ... modulo N.
//   - Within the winning button, short beats long.
//   - Load action: evt_id <= i; evt_long <= chosen type; chosen pend bit cleared; rr_last <= i; evt_valid <= 1.
//   - Transfer edge with no request pending: evt_valid <= 0.
//  Handshake:
//   - evt_id and evt_long stay stable while evt_valid=1 and evt_ready=0.
//   - evt_ready is ignored while evt_valid=0.
//  Latency:
//   - btn_level rises before edge k (prev=0): short_pend set at edge k.
//   - evt_valid=1 after edge k+1 when the output is idle and there is no competition.
//  Simultaneous events on the same pend bit:
//   - Cleared by a load and set by a new rise/long on the same edge: the bit ends at 1 (new event kept).
//   - Set while already 1 and not being cleared that edge: events merge and overrun[i] <= 1.
//  overrun:
//   - Cleared by overrun_clr.
//   - If a set and overrun_clr occur on the same edge, the set wins.
// TESTING
//  T1 (LONG_CYCLES=16, idle, evt_ready=1): btn_level=0100 from edge 10.
//     -> evt_valid=1 after edge 11 for exactly 1 cycle, evt_id=2, evt_long=0. No further event while held <16 cycles.
//  T2 (evt_ready=1): btn_level 0000 -> 1011 on one edge.
//     -> evt_id=0, 1, 3 on 3 consecutive cycles, all evt_long=0; evt_valid then drops.
//  T3 (evt_ready=0): press/release btn1 three times.
//     -> evt_id=1 held stable; overrun=0010 after the 3rd press.
//     -> Raise evt_ready: exactly 2 events with evt_id=1, then evt_valid=0.
//  T4 (LONG_CYCLES=16, evt_ready=1): hold btn0 for 40 cycles.
//     -> Press event, then one evt_long=1 event at 16 cycles + 2 latency after the rise.
//     -> Nothing at release. Release at cycle 10 instead -> no long event.
//  T5 (evt_valid=1, evt_ready=0, others pending): assert rst_n=0 for 1 edge.
//     -> Next cycle evt_valid=0, overrun=0; nothing emitted until new presses arrive.
//  T6: btn_level=0001 held across reset release.
//     -> No event. Release and re-press -> one press event, evt_id=0.

Source files
------------

// File: rtl/button_event_arbiter.sv
// Per-button press / long-press detection with round-robin serialisation onto a
// single valid/ready event port. Overlapping events on one pending flag set a sticky overrun bit.
module button_event_arbiter #(
  parameter int unsigned N           = 4,
  parameter int unsigned IDW         = 2,
  parameter int unsigned LONG_CYCLES = 50000000,
  parameter int unsigned CW          = 26
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   btn_level,
  output logic           evt_valid,
  input  logic           evt_ready,
  output logic [IDW-1:0] evt_id,
  output logic           evt_long,
  output logic [N-1:0]   overrun,
  input  logic           overrun_clr
);

  logic [N-1:0]   btn_prev;
  logic [N-1:0]   short_pend;
  logic [N-1:0]   long_pend;
  logic [N-1:0]   armed;
  logic [CW-1:0]  cnt [N];
  logic [IDW-1:0] rr_last;

  logic [N-1:0]   rise;
  logic [N-1:0]   long_hit;
  logic [N-1:0]   req;
  logic [N-1:0]   clr_short;
  logic [N-1:0]   clr_long;
  logic [N-1:0]   short_keep;
  logic [N-1:0]   long_keep;
  logic [N-1:0]   short_pend_d;
  logic [N-1:0]   long_pend_d;
  logic [N-1:0]   armed_d;
  logic [N-1:0]   overrun_d;
  logic [CW-1:0]  cnt_d [N];
  logic           load_en;
  logic           found;
  logic [IDW-1:0] cand;
  logic [IDW-1:0] win;
  logic           evt_valid_d;
  logic           evt_long_d;
  logic [IDW-1:0] evt_id_d;
  logic [IDW-1:0] rr_last_d;

  assign rise = btn_level & ~btn_prev;
  assign req  = short_pend | long_pend;

  // Hold timer: counts from the press edge, fires once per press.
  always_comb begin
    long_hit = '0;
    armed_d  = armed;
    for (int unsigned i = 0; i < N; i++) begin
      cnt_d[i] = cnt[i];
      if (rise[i]) begin
        armed_d[i] = 1'b1;
        cnt_d[i]   = '0;
      end else if (!btn_level[i]) begin
        armed_d[i] = 1'b0;
        cnt_d[i]   = '0;
      end else if (armed[i]) begin
        cnt_d[i] = cnt[i] + CW'(1);
        if (cnt_d[i] == CW'(LONG_CYCLES)) begin
          long_hit[i] = 1'b1;
          armed_d[i]  = 1'b0;
        end
      end
    end
  end

  // Round-robin winner search starting just after the last served button.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = IDW'((32'(rr_last) + k) % N);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // Output register load and pending-flag bookkeeping.
  always_comb begin
    load_en     = ~evt_valid | evt_ready;
    clr_short   = '0;
    clr_long    = '0;
    evt_valid_d = evt_valid;
    evt_id_d    = evt_id;
    evt_long_d  = evt_long;
    rr_last_d   = rr_last;
    if (load_en) begin
      if (found) begin
        evt_valid_d = 1'b1;
        evt_id_d    = win;
        rr_last_d   = win;
        if (short_pend[win]) begin
          evt_long_d     = 1'b0;
          clr_short[win] = 1'b1;
        end else begin
          evt_long_d    = 1'b1;
          clr_long[win] = 1'b1;
        end
      end else begin
        evt_valid_d = 1'b0;
      end
    end
    // A flag freed on this edge accepts a new event without counting as a merge.
    short_keep   = short_pend & ~clr_short;
    long_keep    = long_pend & ~clr_long;
    short_pend_d = short_keep | rise;
    long_pend_d  = long_keep | long_hit;
    overrun_d    = (overrun & ~{N{overrun_clr}}) | (short_keep & rise) | (long_keep & long_hit);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_prev   <= '1;
      short_pend <= '0;
      long_pend  <= '0;
      armed      <= '0;
      for (int unsigned i = 0; i < N; i++) cnt[i] <= '0;
      rr_last    <= IDW'(N - 1);
      evt_valid  <= 1'b0;
      evt_id     <= '0;
      evt_long   <= 1'b0;
      overrun    <= '0;
    end else begin
      btn_prev   <= btn_level;
      short_pend <= short_pend_d;
      long_pend  <= long_pend_d;
      armed      <= armed_d;
      for (int unsigned i = 0; i < N; i++) cnt[i] <= cnt_d[i];
      rr_last    <= rr_last_d;
      evt_valid  <= evt_valid_d;
      evt_id     <= evt_id_d;
      evt_long   <= evt_long_d;
      overrun    <= overrun_d;
    end
  end

endmodule

// File: tb/tb_button_event_arbiter.sv
// Self-checking bench for button_event_arbiter: directed vector table, hold-timer
// sequences, and randomized stimulus against a timestamp-based reference model.
module tb_button_event_arbiter;

  localparam int unsigned N   = 4;
  localparam int unsigned IDW = 2;
  localparam int unsigned LC  = 16;
  localparam int unsigned CW  = 5;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   btn_level;
  logic           evt_valid;
  logic           evt_ready;
  logic [IDW-1:0] evt_id;
  logic           evt_long;
  logic [N-1:0]   overrun;
  logic           overrun_clr;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  button_event_arbiter #(.N(N), .IDW(IDW), .LONG_CYCLES(LC), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .btn_level(btn_level), .evt_valid(evt_valid),
    .evt_ready(evt_ready), .evt_id(evt_id), .evt_long(evt_long),
    .overrun(overrun), .overrun_clr(overrun_clr)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic [N-1:0] b, input logic rdy, input logic c);
    rst_n = r; btn_level = b; evt_ready = rdy; overrun_clr = c;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pack(input logic v, input logic [1:0] id, input logic l,
                                       input logic [3:0] ovr);
    return {24'd0, v, v ? id : 2'd0, v ? l : 1'b0, ovr};
  endfunction

  function automatic logic [31:0] obs();
    return pack(evt_valid, evt_id, evt_long, overrun);
  endfunction

  // Reference model: events from press timestamps, arbitration by modulo scan.
  bit m_prev[N], m_sp[N], m_lp[N], m_trk[N], m_rise[N], m_lhit[N];
  int m_press[N];
  int m_cyc = 0;
  int m_rr = N - 1;
  int m_j;
  bit m_v = 0, m_l = 0;
  int m_id = 0;
  bit [N-1:0] m_ovr = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        m_prev[i] = 1; m_sp[i] = 0; m_lp[i] = 0; m_trk[i] = 0;
      end
      m_rr = N - 1; m_v = 0; m_id = 0; m_l = 0; m_ovr = '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        m_rise[i] = btn_level[i] && !m_prev[i];
        m_lhit[i] = m_trk[i] && btn_level[i] && (m_cyc - m_press[i] == LC);
      end
      if (!m_v || evt_ready) begin
        m_v = 0;
        for (int k = 1; k <= N; k++) begin
          m_j = (m_rr + k) % N;
          if (!m_v && (m_sp[m_j] || m_lp[m_j])) begin
            m_v = 1; m_id = m_j; m_rr = m_j;
            if (m_sp[m_j]) begin m_l = 0; m_sp[m_j] = 0; end
            else begin m_l = 1; m_lp[m_j] = 0; end
          end
        end
      end
      if (overrun_clr) m_ovr = '0;
      for (int i = 0; i < N; i++) begin
        if (m_rise[i]) begin
          if (m_sp[i]) m_ovr[i] = 1;
          m_sp[i] = 1;
        end
        if (m_lhit[i]) begin
          if (m_lp[i]) m_ovr[i] = 1;
          m_lp[i] = 1;
        end
        if (m_rise[i]) begin m_trk[i] = 1; m_press[i] = m_cyc; end
        else if (!btn_level[i] || m_lhit[i]) m_trk[i] = 0;
        m_prev[i] = btn_level[i];
      end
    end
    m_cyc++;
  end

  typedef struct {
    logic       r;
    logic [3:0] b;
    logic       rdy;
    logic       c;
    logic       v;
    logic [1:0] id;
    logic       l;
    logic [3:0] ovr;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic r, input logic [3:0] b, input logic rdy, input logic c,
                     input logic v, input logic [1:0] id, input logic l, input logic [3:0] ovr);
    vec_t e;
    e.r = r; e.b = b; e.rdy = rdy; e.c = c; e.v = v; e.id = id; e.l = l; e.ovr = ovr;
    tv.push_back(e);
  endtask

  initial begin
    logic [N-1:0] rb;
    rst_n = 1'b0; btn_level = '0; evt_ready = 1'b1; overrun_clr = 1'b0;

    // reset, single press (btn2)
    add(0, 4'b0000, 1, 0, 0, 0, 0, 4'b0000);
    add(1, 4'b0000, 1, 0, 0, 0, 0, 4'b0000);
    add(1, 4'b0100, 1, 0, 0, 0, 0, 4'b0000);
    add(1, 4'b0100, 1, 0, 1, 2, 0, 4'b0000);
    add(1, 4'b0100, 1, 0, 0, 0, 0, 4'b0000);
    add(1, 4'b0000, 1, 0, 0, 0, 0, 4'b0000);
    // simultaneous presses served round-robin after reset
    add(0, 4'b0000, 1, 0, 0, 0, 0, 4'b0000);
    add(1, 4'b0000, 1, 0, 0, 0, 0, 4'b0000);
    add(1, 4'b1011, 1, 0, 0, 0, 0, 4'b0000);
    add(1, 4'b1011, 1, 0, 1, 0, 0, 4'b0000);
    add(1, 4'b1011, 1, 0, 1, 1, 0, 4'b0000);
    add(1, 4'b1011, 1, 0, 1, 3, 0, 4'b0000);
    add(1, 4'b1011, 1, 0, 0, 0, 0, 4'b0000);
    add(1, 4'b0000, 1, 0, 0, 0, 0, 4'b0000);
    // stalled consumer, three presses of btn1 -> overrun
    add(1, 4'b0010, 0, 0, 0, 0, 0, 4'b0000);
    add(1, 4'b0000, 0, 0, 1, 1, 0, 4'b0000);
    add(1, 4'b0010, 0, 0, 1, 1, 0, 4'b0000);
    add(1, 4'b0000, 0, 0, 1, 1, 0, 4'b0000);
    add(1, 4'b0010, 0, 0, 1, 1, 0, 4'b0010);
    add(1, 4'b0000, 1, 0, 1, 1, 0, 4'b0010);
    add(1, 4'b0000, 1, 0, 0, 0, 0, 4'b0010);
    add(1, 4'b0000, 1, 1, 0, 0, 0, 4'b0000);
    // reset mid-handshake drops held and pending events
    add(1, 4'b1001, 0, 0, 0, 0, 0, 4'b0000);
    add(1, 4'b1001, 0, 0, 1, 3, 0, 4'b0000);
    add(0, 4'b1001, 0, 0, 0, 0, 0, 4'b0000);
    add(1, 4'b1001, 1, 0, 0, 0, 0, 4'b0000);
    add(1, 4'b1001, 1, 0, 0, 0, 0, 4'b0000);
    // button held through reset
    add(0, 4'b0001, 1, 0, 0, 0, 0, 4'b0000);
    add(1, 4'b0001, 1, 0, 0, 0, 0, 4'b0000);
    add(1, 4'b0001, 1, 0, 0, 0, 0, 4'b0000);
    add(1, 4'b0000, 1, 0, 0, 0, 0, 4'b0000);
    add(1, 4'b0001, 1, 0, 0, 0, 0, 4'b0000);
    add(1, 4'b0001, 1, 0, 1, 0, 0, 4'b0000);
    add(1, 4'b0001, 1, 0, 0, 0, 0, 4'b0000);
    // overrun set and clear on the same edge: set wins
    add(1, 4'b0101, 0, 0, 0, 0, 0, 4'b0000);
    add(1, 4'b0001, 0, 0, 1, 2, 0, 4'b0000);
    add(1, 4'b0101, 0, 0, 1, 2, 0, 4'b0000);
    add(1, 4'b0001, 0, 0, 1, 2, 0, 4'b0000);
    add(1, 4'b0101, 0, 1, 1, 2, 0, 4'b0100);
    add(1, 4'b0001, 1, 0, 1, 2, 0, 4'b0100);
    add(1, 4'b0001, 1, 0, 0, 0, 0, 4'b0100);

    foreach (tv[k]) begin
      step(tv[k].r, tv[k].b, tv[k].rdy, tv[k].c);
      check($sformatf("vec%0d", k), obs(), pack(tv[k].v, tv[k].id, tv[k].l, tv[k].ovr));
      if (!tv[k].r)
        check($sformatf("vec%0d_rst_raw", k), {29'd0, evt_id, evt_long}, 32'd0);
    end

    // long hold: press event at j=1, long event at j=LC+1, nothing on release
    step(0, 4'b0000, 1, 0);
    step(1, 4'b0000, 1, 0);
    for (int j = 0; j < 40; j++) begin
      step(1, 4'b0001, 1, 0);
      check($sformatf("hold40_j%0d", j), obs(),
            pack((j == 1) || (j == LC + 1), 2'd0, j == LC + 1, 4'b0000));
    end
    for (int j = 0; j < 5; j++) begin
      step(1, 4'b0000, 1, 0);
      check($sformatf("release_j%0d", j), obs(), 32'd0);
    end
    // short hold released before the threshold: no long event
    for (int j = 0; j < 10; j++) begin
      step(1, 4'b0001, 1, 0);
      check($sformatf("hold10_j%0d", j), obs(), pack(j == 1, 2'd0, 1'b0, 4'b0000));
    end
    for (int j = 0; j < 15; j++) begin
      step(1, 4'b0000, 1, 0);
      check($sformatf("after10_j%0d", j), obs(), 32'd0);
    end

    // randomized stimulus against the reference model
    step(0, 4'b0000, 1, 0);
    rb = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 23) == 0) rb[i] = ~rb[i];
      step($urandom_range(0, 499) != 0, rb, $urandom_range(0, 1) != 0,
           $urandom_range(0, 15) == 0);
      check($sformatf("rand%0d", c), obs(), pack(m_v, 2'(m_id), m_l, m_ovr));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
